// File: rtl/fp_pkg.sv
// Shared encodings for the FP hazard scoreboard and the register-file read logic:
// RISC-V F-extension opcodes, OP-FP funct7 values and the bypass-select encoding.
package fp_pkg;

  localparam logic [6:0] FLW    = 7'b0000111;
  localparam logic [6:0] FSW    = 7'b0100111;
  localparam logic [6:0] FMADD  = 7'b1000011;
  localparam logic [6:0] FMSUB  = 7'b1000111;
  localparam logic [6:0] FNMSUB = 7'b1001011;
  localparam logic [6:0] FNMADD = 7'b1001111;
  localparam logic [6:0] OP_FP  = 7'b1010011;

  localparam logic [6:0] F7_FADD    = 7'b0000000;
  localparam logic [6:0] F7_FSUB    = 7'b0000100;
  localparam logic [6:0] F7_FMUL    = 7'b0001000;
  localparam logic [6:0] F7_FDIV    = 7'b0001100;
  localparam logic [6:0] F7_FSQRT   = 7'b0101100;
  localparam logic [6:0] F7_FSGNJ   = 7'b0010000;
  localparam logic [6:0] F7_FMINMAX = 7'b0010100;
  localparam logic [6:0] F7_FCMP    = 7'b1010000;
  localparam logic [6:0] F7_FCVT_WS = 7'b1100000;
  localparam logic [6:0] F7_FMV_XW  = 7'b1110000;
  localparam logic [6:0] F7_FCVT_SW = 7'b1101000;
  localparam logic [6:0] F7_FMV_WX  = 7'b1111000;

  typedef enum logic [1:0] {
    RF_DATA = 2'b01,
    WB_DATA = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fp_src_decode.sv
// Source-operand usage decode for FP instructions: which of rs1/rs2/rs3 are read,
// and whether rs1 comes from the integer file instead of the FP file.
module fp_src_decode
  import fp_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output logic       rs1_is_int,
  output logic       use_rs1,
  output logic       use_rs2,
  output logic       use_rs3
);

  // Loads/stores take an integer base address; only int->FP moves/converts
  // read an integer rs1 among the OP-FP group.
  always_comb begin
    rs1_is_int = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rs3    = 1'b0;
    case (opcode)
      FLW: begin
        use_rs1    = 1'b1;
        rs1_is_int = 1'b1;
      end
      FSW: begin
        use_rs1    = 1'b1;
        rs1_is_int = 1'b1;
        use_rs2    = 1'b1;
      end
      FMADD, FMSUB, FNMSUB, FNMADD: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rs3 = 1'b1;
      end
      OP_FP: begin
        use_rs1    = 1'b1;
        rs1_is_int = (funct7 == F7_FCVT_SW) || (funct7 == F7_FMV_WX);
        case (funct7)
          F7_FADD, F7_FSUB, F7_FMUL, F7_FDIV,
          F7_FSGNJ, F7_FMINMAX, F7_FCMP: use_rs2 = 1'b1;
          default:                       use_rs2 = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fp_hazard_scoreboard.sv
// Per-register pending scoreboard for FP and integer destinations written by FP units.
// Produces WB bypass selects, RAW/WAW/structural issue stall and divider occupancy.
module fp_hazard_scoreboard
  import fp_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  parameter  int DIV_LAT  = 12,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [6:0]          i_opcode,
  input  logic [6:0]          i_funct7,
  input  logic [AW-1:0]       i_rs1,
  input  logic [AW-1:0]       i_rs2,
  input  logic [AW-1:0]       i_rs3,
  input  logic                i_issue_valid,
  input  logic [AW-1:0]       i_issue_rd,
  input  logic                i_issue_fp_rd,
  input  logic                i_issue_writes,
  input  logic                i_issue_iter,
  input  logic                i_wb_valid,
  input  logic [AW-1:0]       i_wb_rd,
  input  logic                i_wb_fp,
  input  logic                i_flush,
  output logic [1:0]          o_forward_a,
  output logic [1:0]          o_forward_b,
  output logic [1:0]          o_forward_c,
  output logic                o_stall,
  output logic                o_div_busy,
  output logic [NUM_REGS-1:0] o_pending_fp,
  output logic [NUM_REGS-1:0] o_pending_int
);

  localparam int                 CW       = $clog2(DIV_LAT);
  localparam logic [CW-1:0]      DIV_LOAD = CW'(DIV_LAT - 1);
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] pend_fp, pend_int, pend_fp_next, pend_int_next;
  logic [NUM_REGS-1:0] wb_clr_fp, wb_clr_int, eff_fp, eff_int;
  logic [NUM_REGS-1:0] set_fp, set_int;
  logic [CW-1:0]       div_cnt, div_cnt_next;
  logic                div_busy_q;
  logic                rs1_is_int, use_rs1, use_rs2, use_rs3;
  logic                raw, waw, structural, accept;
  logic                wb_hit_a, wb_hit_b, wb_hit_c;

  fp_src_decode u_src_decode (
    .opcode     (i_opcode),
    .funct7     (i_funct7),
    .rs1_is_int (rs1_is_int),
    .use_rs1    (use_rs1),
    .use_rs2    (use_rs2),
    .use_rs3    (use_rs3)
  );

  // A writeback landing this cycle already resolves its register, so it is masked
  // out of the hazard view; x0 is never tracked in the integer file.
  assign wb_clr_fp  = (i_wb_valid &  i_wb_fp) ? (ONE_HOT0 << i_wb_rd) : '0;
  assign wb_clr_int = (i_wb_valid & ~i_wb_fp) ? (ONE_HOT0 << i_wb_rd) : '0;
  assign eff_fp     = pend_fp  & ~wb_clr_fp;
  assign eff_int    = pend_int & ~wb_clr_int;

  assign raw = (use_rs1 & (rs1_is_int ? eff_int[i_rs1] : eff_fp[i_rs1]))
             | (use_rs2 & eff_fp[i_rs2])
             | (use_rs3 & eff_fp[i_rs3]);
  assign waw        = i_issue_writes & (i_issue_fp_rd ? eff_fp[i_issue_rd] : eff_int[i_issue_rd]);
  assign structural = i_issue_iter & div_busy_q;
  assign o_stall    = i_issue_valid & (raw | waw | structural);
  assign accept     = i_issue_valid & ~o_stall & ~i_flush;

  assign wb_hit_a = use_rs1 & i_wb_valid & (i_wb_fp == ~rs1_is_int) & (i_wb_rd == i_rs1)
                  & (~rs1_is_int | (i_rs1 != '0));
  assign wb_hit_b = use_rs2 & i_wb_valid & i_wb_fp & (i_wb_rd == i_rs2);
  assign wb_hit_c = use_rs3 & i_wb_valid & i_wb_fp & (i_wb_rd == i_rs3);

  assign o_forward_a = wb_hit_a ? WB_DATA : RF_DATA;
  assign o_forward_b = wb_hit_b ? WB_DATA : RF_DATA;
  assign o_forward_c = wb_hit_c ? WB_DATA : RF_DATA;

  // Set is OR'd after the clear so a same-cycle issue to a retiring register wins.
  always_comb begin
    set_fp  = '0;
    set_int = '0;
    if (accept && i_issue_writes) begin
      if (i_issue_fp_rd)
        set_fp = ONE_HOT0 << i_issue_rd;
      else if (i_issue_rd != '0)
        set_int = ONE_HOT0 << i_issue_rd;
    end
    pend_fp_next  = (pend_fp  & ~wb_clr_fp)  | set_fp;
    pend_int_next = (pend_int & ~wb_clr_int) | set_int;
    div_cnt_next  = div_cnt;
    if (accept && i_issue_iter)
      div_cnt_next = DIV_LOAD;
    else if (div_cnt != '0)
      div_cnt_next = div_cnt - 1'b1;
    if (i_flush) begin
      pend_fp_next  = '0;
      pend_int_next = '0;
      div_cnt_next  = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_fp    <= '0;
      pend_int   <= '0;
      div_cnt    <= '0;
      div_busy_q <= 1'b0;
    end else begin
      pend_fp    <= pend_fp_next;
      pend_int   <= pend_int_next;
      div_cnt    <= div_cnt_next;
      div_busy_q <= (div_cnt_next != '0);
    end
  end

  assign o_div_busy    = div_busy_q;
  assign o_pending_fp  = pend_fp;
  assign o_pending_int = pend_int;

endmodule

// File: tb/tb_fp_hazard_scoreboard.sv
// Directed self-checking bench for fp_hazard_scoreboard (NUM_REGS=32, DIV_LAT=12).
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_fp_hazard_scoreboard;

  localparam logic [6:0] OPC_FP    = 7'b1010011;
  localparam logic [6:0] OPC_FMADD = 7'b1000011;
  localparam logic [6:0] F_ADD     = 7'b0000000;
  localparam logic [6:0] F_MUL     = 7'b0001000;
  localparam logic [6:0] F_DIV     = 7'b0001100;
  localparam logic [6:0] F_SQRT    = 7'b0101100;
  localparam logic [6:0] F_CVT_WS  = 7'b1100000;
  localparam logic [6:0] F_CVT_SW  = 7'b1101000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rs1, rs2, rs3, issue_rd, wb_rd;
  logic        issue_valid, issue_fp_rd, issue_writes, issue_iter;
  logic        wb_valid, wb_fp, flush;
  logic [1:0]  forward_a, forward_b, forward_c;
  logic        stall, div_busy;
  logic [31:0] pending_fp, pending_int;

  int checks   = 0;
  int failures = 0;

  fp_hazard_scoreboard #(.NUM_REGS(32), .DIV_LAT(12)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_opcode       (opcode),
    .i_funct7       (funct7),
    .i_rs1          (rs1),
    .i_rs2          (rs2),
    .i_rs3          (rs3),
    .i_issue_valid  (issue_valid),
    .i_issue_rd     (issue_rd),
    .i_issue_fp_rd  (issue_fp_rd),
    .i_issue_writes (issue_writes),
    .i_issue_iter   (issue_iter),
    .i_wb_valid     (wb_valid),
    .i_wb_rd        (wb_rd),
    .i_wb_fp        (wb_fp),
    .i_flush        (flush),
    .o_forward_a    (forward_a),
    .o_forward_b    (forward_b),
    .o_forward_c    (forward_c),
    .o_stall        (stall),
    .o_div_busy     (div_busy),
    .o_pending_fp   (pending_fp),
    .o_pending_int  (pending_int)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    opcode = 7'b0110011; funct7 = 7'd0;
    rs1 = 5'd0; rs2 = 5'd0; rs3 = 5'd0;
    issue_valid = 1'b0; issue_rd = 5'd0; issue_fp_rd = 1'b0;
    issue_writes = 1'b0; issue_iter = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_fp = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_issue(input logic [6:0] op, input logic [6:0] f7,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                             input logic [4:0] rd, input logic fp_rd, input logic iter);
    opcode = op; funct7 = f7; rs1 = r1; rs2 = r2; rs3 = r3;
    issue_valid = 1'b1; issue_rd = rd; issue_fp_rd = fp_rd;
    issue_writes = 1'b1; issue_iter = iter;
  endtask

  task automatic drive_wb(input logic [4:0] rd, input logic fp);
    wb_valid = 1'b1; wb_rd = rd; wb_fp = fp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (pending_fp !== 32'h0 || pending_int !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_pending: got fp=%h int=%h expected 0/0", pending_fp, pending_int);
    end
    checks++;
    if (div_busy !== 1'b0 || stall !== 1'b0 || forward_a !== 2'b01 || forward_b !== 2'b01 || forward_c !== 2'b01) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got busy=%b stall=%b fwd=%b/%b/%b expected 0 0 01/01/01",
               div_busy, stall, forward_a, forward_b, forward_c);
    end
    drive_issue(OPC_FP, F_DIV, 5'd1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
    step();
    drive_issue(OPC_FP, F_ADD, 5'd1, 5'd2, 5'd0, 5'd4, 1'b1, 1'b0);
    step();
    drive_issue(OPC_FP, F_MUL, 5'd3, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0);
    #1;
    checks++;
    if (pending_fp !== 32'h18 || div_busy !== 1'b1 || stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midop_state: got fp=%h busy=%b stall=%b expected 00000018 1 1",
               pending_fp, div_busy, stall);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pending_fp !== 32'h0 || div_busy !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset: got fp=%h busy=%b stall=%b expected 0 0 0",
               pending_fp, div_busy, stall);
    end
    drive_idle();
    step();
    rst = 1'b0;
  endtask

  task automatic test_raw_bypass();
    do_reset();
    drive_issue(OPC_FP, F_ADD, 5'd1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL raw_first_issue: got stall=%b expected 0", stall);
    end
    step();
    drive_issue(OPC_FP, F_MUL, 5'd6, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1 || forward_b !== 2'b01 || pending_fp !== 32'h20) begin
      failures++;
      $display("[TB] FAIL raw_stall: got stall=%b fwd_b=%b fp=%h expected 1 01 00000020",
               stall, forward_b, pending_fp);
    end
    step();
    drive_wb(5'd5, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0 || forward_b !== 2'b10 || forward_a !== 2'b01) begin
      failures++;
      $display("[TB] FAIL raw_bypass: got stall=%b fwd_a=%b fwd_b=%b expected 0 01 10",
               stall, forward_a, forward_b);
    end
    step();
    drive_idle();
    #1;
    checks++;
    if (pending_fp !== 32'h100) begin
      failures++;
      $display("[TB] FAIL raw_after_accept: got fp=%h expected 00000100", pending_fp);
    end
  endtask

  task automatic test_rs3_decode();
    do_reset();
    drive_issue(OPC_FP, F_ADD, 5'd1, 5'd2, 5'd0, 5'd20, 1'b1, 1'b0);
    step();
    drive_issue(OPC_FMADD, 7'd0, 5'd1, 5'd2, 5'd20, 5'd21, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1 || forward_c !== 2'b01) begin
      failures++;
      $display("[TB] FAIL rs3_stall: got stall=%b fwd_c=%b expected 1 01", stall, forward_c);
    end
    drive_wb(5'd20, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0 || forward_c !== 2'b10 || forward_a !== 2'b01) begin
      failures++;
      $display("[TB] FAIL rs3_bypass: got stall=%b fwd_c=%b fwd_a=%b expected 0 10 01",
               stall, forward_c, forward_a);
    end
    wb_valid = 1'b0;
    drive_issue(OPC_FP, F_SQRT, 5'd1, 5'd20, 5'd20, 5'd22, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sqrt_rs2_unused: got stall=%b expected 0", stall);
    end
    drive_wb(5'd20, 1'b1);
    #1;
    checks++;
    if (forward_b !== 2'b01 || forward_c !== 2'b01) begin
      failures++;
      $display("[TB] FAIL sqrt_no_fwd: got fwd_b=%b fwd_c=%b expected 01 01", forward_b, forward_c);
    end
    drive_idle();
  endtask

  task automatic test_file_sep();
    do_reset();
    drive_issue(OPC_FP, F_CVT_WS, 5'd1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
    step();
    drive_issue(OPC_FP, F_ADD, 5'd7, 5'd1, 5'd0, 5'd10, 1'b1, 1'b0);
    #1;
    checks++;
    if (pending_int !== 32'h80 || pending_fp !== 32'h0 || stall !== 1'b0 || forward_a !== 2'b01) begin
      failures++;
      $display("[TB] FAIL filesep_fp_src: got int=%h fp=%h stall=%b fwd_a=%b expected 00000080 0 0 01",
               pending_int, pending_fp, stall, forward_a);
    end
    drive_issue(OPC_FP, F_CVT_SW, 5'd7, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL filesep_int_src: got stall=%b expected 1", stall);
    end
    drive_wb(5'd7, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0 || forward_a !== 2'b10) begin
      failures++;
      $display("[TB] FAIL filesep_int_bypass: got stall=%b fwd_a=%b expected 0 10", stall, forward_a);
    end
    issue_valid = 1'b0;
    step();
    drive_idle();
    drive_issue(OPC_FP, F_CVT_WS, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    drive_idle();
    #1;
    checks++;
    if (pending_int !== 32'h0 || pending_fp !== 32'h0) begin
      failures++;
      $display("[TB] FAIL filesep_x0: got int=%h fp=%h expected 0 0", pending_int, pending_fp);
    end
  endtask

  task automatic test_struct();
    int busy_cycles;
    do_reset();
    busy_cycles = 0;
    drive_issue(OPC_FP, F_DIV, 5'd1, 5'd2, 5'd0, 5'd12, 1'b1, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0 || div_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL div_issue: got stall=%b busy=%b expected 0 0", stall, div_busy);
    end
    step();
    drive_idle();
    for (int k = 1; k <= 11; k++) begin
      if (k == 5)
        drive_issue(OPC_FP, F_SQRT, 5'd3, 5'd0, 5'd0, 5'd13, 1'b1, 1'b1);
      #1;
      if (div_busy === 1'b1) busy_cycles++;
      if (k == 5) begin
        checks++;
        if (stall !== 1'b1) begin
          failures++;
          $display("[TB] FAIL struct_stall: got stall=%b expected 1", stall);
        end
      end
      drive_idle();
      step();
    end
    checks++;
    if (busy_cycles !== 11) begin
      failures++;
      $display("[TB] FAIL div_busy_len: got %0d expected 11", busy_cycles);
    end
    drive_issue(OPC_FP, F_SQRT, 5'd3, 5'd0, 5'd0, 5'd13, 1'b1, 1'b1);
    #1;
    checks++;
    if (div_busy !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL struct_accept: got busy=%b stall=%b expected 0 0", div_busy, stall);
    end
    step();
    drive_idle();
    #1;
    checks++;
    if (div_busy !== 1'b1 || pending_fp !== 32'h3000) begin
      failures++;
      $display("[TB] FAIL sqrt_started: got busy=%b fp=%h expected 1 00003000", div_busy, pending_fp);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive_issue(OPC_FP, F_ADD, 5'd1, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0);
    step();
    drive_issue(OPC_FP, F_ADD, 5'd3, 5'd4, 5'd0, 5'd9, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL waw_stall: got stall=%b expected 1", stall);
    end
    drive_wb(5'd9, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL waw_wb_release: got stall=%b expected 0", stall);
    end
    step();
    drive_idle();
    #1;
    checks++;
    if (pending_fp !== 32'h200) begin
      failures++;
      $display("[TB] FAIL set_wins: got fp=%h expected 00000200", pending_fp);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive_issue(OPC_FP, F_ADD, 5'd3, 5'd4, 5'd0, 5'd1, 1'b1, 1'b0);
    step();
    drive_issue(OPC_FP, F_ADD, 5'd3, 5'd4, 5'd0, 5'd2, 1'b1, 1'b0);
    step();
    drive_issue(OPC_FP, F_DIV, 5'd3, 5'd4, 5'd0, 5'd6, 1'b1, 1'b1);
    step();
    drive_issue(OPC_FP, F_ADD, 5'd5, 5'd7, 5'd0, 5'd10, 1'b1, 1'b0);
    #1;
    checks++;
    if (pending_fp !== 32'h46 || div_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_setup: got fp=%h busy=%b expected 00000046 1", pending_fp, div_busy);
    end
    flush = 1'b1;
    step();
    drive_idle();
    #1;
    checks++;
    if (pending_fp !== 32'h0 || pending_int !== 32'h0 || div_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_clear: got fp=%h int=%h busy=%b expected 0 0 0",
               pending_fp, pending_int, div_busy);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_raw_bypass();
    test_rs3_decode();
    test_file_sep();
    test_struct();
    test_simultaneous();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
